pc_seq: RTL and testbench

Parametrised program-counter sequencer for the core fetch stage, successor to the fixed 64-bit PC. Holds the fetch address and updates it once per cycle from trap entry, absolute load, return-stack pop, PC-relative branch or sequential increment. Width, reset vector and return-address-stack depth are parameters. An optional return-address stack (RAS) supports call/return.

---
 rtl/pc_seq.sv | 168 ++++++++++++++++
 tb/tb_pc_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch stage: trap, load, return-stack pop, branch or step.
// Optional return-address stack built only when PC_RAS_EN is defined.
module pc_seq #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic [XLEN-1:0] tvec,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    input  logic            call,
    input  logic            ret,
    input  logic            br,
    input  logic [XLEN-1:0] off,
    input  logic [1:0]      inc,
    output logic [XLEN-1:0] q,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_uflow
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] step_s;
    logic [XLEN-1:0] ret_addr_s;
    logic [XLEN-1:0] ras_top_s;
    logic            call_en_s;
    logic            ret_en_s;
    logic            ras_has_s;
    logic            push_s;
    logic            pop_s;
    logic            uflow_nxt_s;

    // Decode the sequential step size from inc.
    always_comb begin
        step_s = {XLEN{1'b0}};
        case (inc)
            2'b00:   step_s = {XLEN{1'b0}};
            2'b01:   step_s = XLEN'(4'd1);
            2'b10:   step_s = XLEN'(4'd4);
            2'b11:   step_s = XLEN'(4'd8);
            default: step_s = {XLEN{1'b0}};
        endcase
    end

    assign ret_addr_s = pc_r + step_s;

    // Prioritised next-PC selection and stack push/pop requests.
    always_comb begin
        pc_nxt_s    = pc_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        uflow_nxt_s = 1'b0;
        if (trap) begin
            pc_nxt_s = tvec;
        end else if (stall) begin
            pc_nxt_s = pc_r;
        end else if (load) begin
            pc_nxt_s = d;
            push_s   = call_en_s;
        end else if (ret_en_s && ras_has_s) begin
            pc_nxt_s = ras_top_s;
            pop_s    = 1'b1;
        end else if (ret_en_s) begin
            pc_nxt_s    = ret_addr_s;
            uflow_nxt_s = 1'b1;
        end else if (br) begin
            pc_nxt_s = pc_r + off;
        end else begin
            pc_nxt_s = ret_addr_s;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_VEC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    assign q = pc_r;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]   top_r;
    logic [PW-1:0]   top_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            empty_r;
    logic            full_r;
    logic            uflow_r;

    assign call_en_s = call;
    assign ret_en_s  = ret;
    assign ras_has_s = (cnt_r != CW'(1'b0));
    assign ras_top_s = ras_mem_r[top_r];

    // Pointer and count update; a push while full reuses the oldest slot.
    always_comb begin
        top_nxt_s = top_r;
        cnt_nxt_s = cnt_r;
        if (push_s) begin
            top_nxt_s = top_r + PW'(1'b1);
            if (cnt_r == CW'(RAS_DEPTH)) begin
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = cnt_r + CW'(1'b1);
            end
        end else if (pop_s) begin
            top_nxt_s = top_r - PW'(1'b1);
            cnt_nxt_s = cnt_r - CW'(1'b1);
        end else begin
            top_nxt_s = top_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Stack bookkeeping and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_r   <= PW'(1'b0);
            cnt_r   <= CW'(1'b0);
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            uflow_r <= 1'b0;
        end else begin
            top_r   <= top_nxt_s;
            cnt_r   <= cnt_nxt_s;
            empty_r <= (cnt_nxt_s == CW'(1'b0));
            full_r  <= (cnt_nxt_s == CW'(RAS_DEPTH));
            uflow_r <= uflow_nxt_s;
        end
    end

    // Return-address storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ras_mem_r[top_nxt_s] <= ret_addr_s;
        end
    end

    assign ras_empty = empty_r;
    assign ras_full  = full_r;
    assign ras_uflow = uflow_r;
`else
    logic unused_s;

    assign call_en_s = 1'b0;
    assign ret_en_s  = 1'b0;
    assign ras_has_s = 1'b0;
    assign ras_top_s = {XLEN{1'b0}};
    assign unused_s  = ^{call, ret, push_s, pop_s, uflow_nxt_s};

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_uflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a behavioural model queues expected outputs per driven cycle.
// Expectations follow the PC_RAS_EN setting of the build.
module tb_pc_seq;

    localparam int          XLEN  = 64;
    localparam logic [63:0] RV    = 64'h0000_0000_0000_1000;
    localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap;
    logic [63:0] tvec;
    logic        load;
    logic [63:0] d;
    logic        call;
    logic        ret;
    logic        br;
    logic [63:0] off;
    logic [1:0]  inc;
    logic [63:0] q;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_uflow;

    typedef struct {
        string       tag;
        logic [63:0] q;
        logic        e;
        logic        f;
        logic        u;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_q;
    logic [63:0] m_ras[$];
    int          check_cnt;
    int          error_cnt;

    pc_seq #(.XLEN(XLEN), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .tvec(tvec),
        .load(load), .d(d), .call(call), .ret(ret), .br(br), .off(off),
        .inc(inc), .q(q), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_uflow(ras_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt = check_cnt + 1;
        if (obs !== exp) begin
            error_cnt = error_cnt + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] stepv(input logic [1:0] i);
        case (i)
            2'b00:   return 64'd0;
            2'b01:   return 64'd1;
            2'b10:   return 64'd4;
            default: return 64'd8;
        endcase
    endfunction

    task automatic idle();
        stall = 1'b0; trap = 1'b0; tvec = 64'd0; load = 1'b0; d = 64'd0;
        call = 1'b0; ret = 1'b0; br = 1'b0; off = 64'd0; inc = 2'b10;
    endtask

    // Apply the current inputs to the model and queue the expected outputs.
    task automatic model_step(input string tag);
        exp_t        e;
        logic [63:0] nxt;
        logic        uf;
        uf  = 1'b0;
        nxt = m_q + stepv(inc);
        if (trap) begin
            m_q = tvec;
        end else if (stall) begin
            m_q = m_q;
        end else if (load) begin
            if (RAS_EN && call) begin
                if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                m_ras.push_back(nxt);
            end
            m_q = d;
        end else if (RAS_EN && ret && m_ras.size() > 0) begin
            m_q = m_ras.pop_back();
        end else if (RAS_EN && ret) begin
            m_q = nxt;
            uf  = 1'b1;
        end else if (br) begin
            m_q = m_q + off;
        end else begin
            m_q = nxt;
        end
        e.tag = tag;
        e.q   = m_q;
        e.e   = (m_ras.size() == 0);
        e.f   = (m_ras.size() == DEPTH);
        e.u   = uf;
        sb.push_back(e);
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        model_step(tag);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".q"}, q, e.q);
        chk({e.tag, ".empty"}, {63'd0, ras_empty}, {63'd0, e.e});
        chk({e.tag, ".full"}, {63'd0, ras_full}, {63'd0, e.f});
        chk({e.tag, ".uflow"}, {63'd0, ras_uflow}, {63'd0, e.u});
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst.q", q, RV);
        chk("rst.empty", {63'd0, ras_empty}, 64'd1);
        chk("rst.full", {63'd0, ras_full}, 64'd0);
        chk("rst.uflow", {63'd0, ras_uflow}, 64'd0);
        m_q = RV;
        m_ras.delete();
        @(negedge clk);
        rst = 1'b0;

        // sequential +4 from the reset vector
        for (int i = 0; i < 4; i++) cycle("inc4");
        chk("inc4.end", q, 64'h1010);

        // branch backwards through zero, then +8 wrap
        idle(); load = 1'b1; d = 64'h10; inc = 2'b00; cycle("ld10");
        idle(); br = 1'b1; off = -64'sd32; cycle("brneg");
        chk("brneg.abs", q, 64'hFFFF_FFFF_FFFF_FFF0);
        idle(); inc = 2'b11; cycle("wrap1");
        cycle("wrap2");
        chk("wrap.abs", q, 64'h0);

        // call / return
        idle(); load = 1'b1; d = 64'h200; cycle("ld200");
        idle(); load = 1'b1; call = 1'b1; d = 64'h800; cycle("call");
        chk("call.abs", q, 64'h800);
        idle(); ret = 1'b1; cycle("ret");
        chk("ret.abs", q, RAS_EN ? 64'h204 : 64'h804);

        // overflow with five calls, then drain past empty
        for (int k = 1; k <= 5; k++) begin
            idle(); load = 1'b1; call = 1'b1; d = 64'h1_0000 * k; cycle("ovf");
        end
        chk("ovf.full", {63'd0, ras_full}, {63'd0, RAS_EN});
        for (int k = 0; k < 5; k++) begin
            idle(); ret = 1'b1; inc = 2'b01; cycle("drain");
        end
        chk("drain.uflow", {63'd0, ras_uflow}, {63'd0, RAS_EN});

        // priority and stall
        idle(); stall = 1'b1; load = 1'b1; d = 64'h4000; cycle("stall_ld");
        idle(); stall = 1'b1; trap = 1'b1; tvec = 64'h80; cycle("stall_trap");
        chk("stall_trap.abs", q, 64'h80);
        idle(); load = 1'b1; call = 1'b1; d = 64'h900; cycle("pre_trap");
        idle(); trap = 1'b1; load = 1'b1; call = 1'b1; tvec = 64'h40; d = 64'h1234; cycle("trap_call");
        chk("trap_call.abs", q, 64'h40);
        idle(); ret = 1'b1; inc = 2'b01; cycle("bb_ret");
        idle(); load = 1'b1; call = 1'b1; d = 64'h500; cycle("bb_call");
        idle(); ret = 1'b1; cycle("bb_ret2");

        // randomized mix
        for (int i = 0; i < 200; i++) begin
            idle();
            trap  = ($urandom_range(15) == 0);
            stall = ($urandom_range(7) == 0);
            load  = ($urandom_range(3) == 0);
            call  = $urandom_range(1);
            ret   = ($urandom_range(2) == 0);
            br    = ($urandom_range(3) == 0);
            inc   = 2'($urandom_range(3));
            tvec  = {$urandom, $urandom};
            d     = {$urandom, $urandom};
            off   = {$urandom, $urandom};
            cycle("rand");
        end

        // asynchronous reset in the middle of a call
        idle(); load = 1'b1; call = 1'b1; d = 64'h700; cycle("pre_rst");
        idle(); load = 1'b1; call = 1'b1; d = 64'h780;
        #2 rst = 1'b1;
        #1;
        chk("arst.q", q, RV);
        chk("arst.empty", {63'd0, ras_empty}, 64'd1);
        chk("arst.uflow", {63'd0, ras_uflow}, 64'd0);
        m_q = RV;
        m_ras.delete();
        @(negedge clk);
        chk("arst.hold", q, RV);
        rst = 1'b0;
        idle(); ret = 1'b1; cycle("post_rst_ret");
        chk("post_rst_ret.abs", q, RV + 64'd4);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
